// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one byte UART transmitter among 4 packet requesters
module uart_tx_arbiter #(
  parameter int PKT_GAP = 0
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic [3:0]  req,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_len,
  input  logic [31:0] req_data,
  output logic [3:0]  grant,
  output logic [3:0]  rd_ack,
  output logic [3:0]  done,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_busy
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  logic [2:0] state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d, win_q, win_d;
  logic [3:0] grant_q, grant_d, len_q, len_d, idx_q, idx_d;
  logic [7:0] addr_q, addr_d, sum_q, sum_d, tx_data_q, tx_data_d, gap_q, gap_d;
  logic [4:0] k_q, k_d;
  logic [7:0] pbuf_q [16];
  logic [7:0] pbuf_d [16];
  logic [1:0] pick, c;
  logic [7:0] ld_byte, sum_ld, next_byte;
  logic [4:0] k_nx;
  logic       last_k;
  always_comb begin
    pick = rr_ptr_q;
    c = '0;
    for (int j = 4; j >= 1; j--) begin
      c = rr_ptr_q + 2'(j);
      if (req[c]) pick = c;
    end
  end
  assign ld_byte   = req_data[{win_q, 3'b000} +: 8];
  assign sum_ld    = sum_q + ld_byte;
  assign k_nx      = k_q + 5'd1;
  assign last_k    = k_q == {1'b0, len_q} + 5'd3;
  assign next_byte = k_nx == 5'd1 ? addr_q :
                     k_nx == 5'd2 ? {4'b0, len_q} + 8'd1 : pbuf_q[4'(k_nx - 5'd3)];
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    grant_d   = grant_q;
    len_d     = len_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    sum_d     = sum_q;
    tx_data_d = tx_data_q;
    gap_d     = gap_q;
    k_d       = k_q;
    pbuf_d    = pbuf_q;
    case (state_q)
      S_IDLE: if (|req) begin
        win_d   = pick;
        grant_d = 4'b0001 << pick;
        addr_d  = req_addr[{pick, 3'b000} +: 8];
        len_d   = req_len[{pick, 2'b00} +: 4];
        sum_d   = req_addr[{pick, 3'b000} +: 8] + {4'b0, req_len[{pick, 2'b00} +: 4]} + 8'd1;
        idx_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        pbuf_d[idx_q] = ld_byte;
        sum_d = sum_ld;
        idx_d = idx_q + 4'd1;
        // checksum byte is latched as the first frame byte together with the last payload byte
        if (idx_q == len_q) begin
          k_d       = '0;
          tx_data_d = 8'd0 - sum_ld;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: state_d = tx_busy ? S_ISSUE : S_HOLD;
      S_HOLD:  state_d = S_DRAIN;
      S_DRAIN: if (!tx_busy) begin
        if (last_k) begin
          rr_ptr_d = win_q;
          grant_d  = '0;
          gap_d    = '0;
          state_d  = (PKT_GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          k_d       = k_nx;
          tx_data_d = next_byte;
          state_d   = S_ISSUE;
        end
      end
      S_GAP: begin
        gap_d   = gap_q + 8'd1;
        state_d = (gap_q == 8'(PKT_GAP - 1)) ? S_IDLE : S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= 2'd3;
      win_q     <= '0;
      grant_q   <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      sum_q     <= '0;
      tx_data_q <= '0;
      gap_q     <= '0;
      k_q       <= '0;
      pbuf_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      grant_q   <= grant_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      sum_q     <= sum_d;
      tx_data_q <= tx_data_d;
      gap_q     <= gap_d;
      k_q       <= k_d;
      pbuf_q    <= pbuf_d;
    end
  end
  assign grant   = grant_q;
  assign rd_ack  = state_q == S_LOAD ? grant_q : 4'b0;
  assign done    = (state_q == S_DRAIN && !tx_busy && last_k) ? grant_q : 4'b0;
  assign busy    = state_q != S_IDLE;
  assign tx_send = state_q == S_ISSUE && !tx_busy;
  assign tx_data = tx_data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random packets against a frame/round-robin reference model
module tb_uart_tx_arbiter;
  localparam int GAP = 3;
  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic [31:0] req_data;
  logic [3:0]  grant, rd_ack, done;
  logic        busy, tx_send, tx_busy;
  logic [7:0]  tx_data;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] pd [4][16];
  logic [4:0] ptr [4] = '{default: '0};
  int txc = 2;
  int tx_cnt = 0;
  logic force_busy = 1'b0;
  logic [7:0] cap [$];
  int acks [4];
  int first_ack = -1;
  int last_ack = 0;
  int cyc = 0;
  logic [3:0] prev_grant = '0;
  logic prev_done = 1'b0;
  int grant_glitch = 0;
  int rr = 3;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.PKT_GAP(GAP)) dut (
    .clk(clk), .RESET_N(RESET_N), .req(req), .req_addr(req_addr), .req_len(req_len),
    .req_data(req_data), .grant(grant), .rd_ack(rd_ack), .done(done), .busy(busy),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy)
  );

  always_comb for (int i = 0; i < 4; i++) req_data[8*i +: 8] = pd[i][ptr[i][3:0]];

  always @(posedge clk) for (int i = 0; i < 4; i++) ptr[i] <= grant[i] ? ptr[i] + 5'(rd_ack[i]) : 5'd0;

  always @(posedge clk or negedge RESET_N)
    if (!RESET_N) tx_cnt <= 0;
    else if (tx_send) tx_cnt <= txc;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  assign tx_busy = tx_cnt != 0 || force_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (tx_send) begin
      chk("send_while_busy", 32'(tx_busy), 32'd0);
      cap.push_back(tx_data);
    end
    if (|rd_ack) begin
      chk("ack_vs_grant", 32'(rd_ack), 32'(grant));
      for (int i = 0; i < 4; i++) if (rd_ack[i]) acks[i]++;
      if (first_ack < 0) first_ack = cyc;
      last_ack = cyc;
    end
    if (|done) chk("done_vs_grant", 32'(done), 32'(grant));
    if (!RESET_N) prev_grant = '0;
    else if (prev_grant != 0 && grant != prev_grant && !prev_done) grant_glitch++;
    prev_grant = grant;
    prev_done = |done;
  end

  function automatic int model_pick(input logic [3:0] m, input int from);
    for (int j = 1; j <= 4; j++) if (m[(from + j) % 4]) return (from + j) % 4;
    return 0;
  endfunction

  task automatic set_rand(input int i, input int n);
    req_addr[8*i +: 8] = 8'($urandom);
    req_len[4*i +: 4] = 4'(n - 1);
    for (int j = 0; j < 16; j++) pd[i][j] = 8'($urandom);
  endtask

  task automatic do_packet(input logic [3:0] mask, input bit keep, input int bp_at,
                           input string tag, output int w);
    logic [7:0] exp [$];
    int n, tot, t;
    bit bp;
    w = model_pick(mask, rr);
    n = int'(req_len[4*w +: 4]) + 1;
    tot = int'(req_addr[8*w +: 8]) + n;
    for (int i = 0; i < n; i++) tot += int'(pd[w][i]);
    exp.push_back(8'((256 - tot % 256) % 256));
    exp.push_back(req_addr[8*w +: 8]);
    exp.push_back(8'(n));
    for (int i = 0; i < n; i++) exp.push_back(pd[w][i]);
    cap.delete();
    acks = '{default: 0};
    first_ack = -1;
    grant_glitch = 0;
    bp = 1'b0;
    req = mask;
    @(negedge clk);
    chk({tag, "_grant"}, 32'(grant), 32'(4'b0001 << w));
    t = 0;
    while (done == 0 && t < 3000) begin
      @(negedge clk);
      t++;
      if (bp_at >= 0 && !bp && cap.size() == bp_at) begin
        bp = 1'b1;
        @(negedge clk);
        force_busy = 1'b1;
        repeat (500) @(negedge clk);
        force_busy = 1'b0;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'(4'b0001 << w));
    if (!keep) req = '0;
    rr = w;
    chk({tag, "_acks"}, 32'(acks[w]), 32'(n));
    chk({tag, "_ack_span"}, 32'(last_ack - first_ack), 32'(n - 1));
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_gap"}, 32'(t), 32'(GAP + 1));
    chk({tag, "_grant_held"}, 32'(grant_glitch), 32'd0);
    chk({tag, "_len"}, 32'(cap.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk({tag, $sformatf("_b%0d", i)}, 32'(i < cap.size() ? cap[i] : 8'hxx), 32'(exp[i]));
  endtask

  initial begin
    int t, w;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 16; j++) pd[i][j] = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_rd_ack", 32'(rd_ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_send", 32'(tx_send), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    RESET_N = 1'b1;
    @(negedge clk);
    txc = 2;
    for (int i = 0; i < 4; i++) set_rand(i, 1);
    for (int k = 0; k < 5; k++) begin
      do_packet(4'hF, k < 4, -1, "rr", w);
      chk("rr_order", 32'(w), 32'(k % 4));
    end
    txc = 10;
    req_addr[7:0] = 8'h10;
    req_len[3:0] = 4'd0;
    pd[0][0] = 8'h55;
    do_packet(4'b0001, 1'b0, -1, "single", w);
    chk("single_ck", 32'(cap[0]), 32'h9A);
    txc = 3;
    req_addr[31:24] = 8'hFF;
    req_len[15:12] = 4'd1;
    pd[3][0] = 8'hFF;
    pd[3][1] = 8'hFF;
    do_packet(4'b1000, 1'b0, -1, "wrap", w);
    chk("wrap_ck", 32'(cap[0]), 32'h01);
    chk("wrap_cnt", 32'(cap[2]), 32'h02);
    req_addr[23:16] = 8'($urandom);
    req_len[11:8] = 4'hF;
    for (int j = 0; j < 16; j++) pd[2][j] = 8'(j);
    do_packet(4'b0100, 1'b0, -1, "max", w);
    chk("max_cnt", 32'(cap[2]), 32'h10);
    repeat (8) begin
      txc = $urandom_range(1, 6);
      for (int i = 0; i < 4; i++) set_rand(i, $urandom_range(1, 16));
      do_packet(4'($urandom_range(1, 15)), 1'b0, -1, "rand", w);
    end
    txc = 3;
    set_rand(0, 8);
    do_packet(4'b0001, 1'b0, 4, "bp", w);
    set_rand(2, 4);
    cap.delete();
    req = 4'b0100;
    t = 0;
    while (cap.size() < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_reach", 32'(cap.size()), 32'd3);
    #2 RESET_N = 1'b0;
    #1;
    chk("mid_grant", 32'(grant), 32'd0);
    chk("mid_rd_ack", 32'(rd_ack), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_tx_send", 32'(tx_send), 32'd0);
    chk("mid_tx_data", 32'(tx_data), 32'd0);
    req = '0;
    repeat (3) @(negedge clk);
    RESET_N = 1'b1;
    rr = 3;
    @(negedge clk);
    set_rand(0, 2);
    set_rand(1, 3);
    do_packet(4'b0011, 1'b0, -1, "post_rst_rr", w);
    chk("post_rst_winner", 32'(w), 32'd0);
    do_packet(4'b0010, 1'b0, -1, "post_rst_r1", w);
    chk("post_rst_r1_winner", 32'(w), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
